// File: rtl/mux_94_arbiter.sv
// Round-robin owner arbiter for a shared mux_94 word bus, with a hold limit and a blanked handover.
// Latency: grant, sel and mux_blank are registered and appear one clock after the request is sampled.
// Backpressure: an owner keeps the bus until it signals last, drops req, or reaches MAX_HOLD cycles.
module mux_94_arbiter #(
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mux_blank,
    output logic       busy,
    output logic       timeout
);

    // TURN spans the turnaround cycles plus the release slot, so a handover
    // always shows TURN_CYCLES+1 blank cycles on the bus.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [2:0] TURN_END   = 3'(TURN_CYCLES + 1);
    localparam bit         HAS_TURN   = (TURN_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [7:0] hold_cnt, hold_n;
    logic [2:0] turn_cnt, turn_n;
    logic [3:0] grant_n;
    logic [1:0] sel_n;
    logic       mux_blank_n, busy_n, timeout_n;

    logic [2:0] win_idle;
    logic [2:0] win_rel;
    logic       rel_norm, rel_max;
    logic       do_take;
    logic [1:0] take_idx;

    // Returns {found, index}: first set request bit searching from p upward, modulo 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Winners for arbitration from the stored pointer and from the pointer a release would set.
    always_comb begin
        win_idle = pick(req, ptr);
        win_rel  = pick(req, sel + 2'd1);
        rel_norm = last[sel] | ~req[sel];
        rel_max  = (HOLD_LIMIT != 8'd0) && (hold_cnt == HOLD_LIMIT);
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_n      = hold_cnt;
        turn_n      = turn_cnt;
        grant_n     = grant;
        sel_n       = sel;
        mux_blank_n = mux_blank;
        busy_n      = busy;
        timeout_n   = 1'b0;
        do_take     = 1'b0;
        take_idx    = 2'd0;

        unique case (state)
            IDLE: begin
                grant_n     = 4'b0000;
                mux_blank_n = 1'b1;
                busy_n      = 1'b0;
                if (win_idle[2]) begin
                    do_take  = 1'b1;
                    take_idx = win_idle[1:0];
                end
            end
            OWN: begin
                if (rel_norm || rel_max) begin
                    // A forced release is reported only when no normal release applies.
                    timeout_n   = ~rel_norm;
                    ptr_n       = sel + 2'd1;
                    grant_n     = 4'b0000;
                    busy_n      = 1'b0;
                    mux_blank_n = 1'b1;
                    state_n     = IDLE;
                    if (HAS_TURN) begin
                        state_n = TURN;
                        turn_n  = 3'd1;
                    end else if (win_rel[2]) begin
                        do_take  = 1'b1;
                        take_idx = win_rel[1:0];
                    end
                end else if (hold_cnt != 8'hFF) begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            TURN: begin
                grant_n     = 4'b0000;
                mux_blank_n = 1'b1;
                busy_n      = 1'b0;
                if (turn_cnt == TURN_END) begin
                    state_n = IDLE;
                    if (win_idle[2]) begin
                        do_take  = 1'b1;
                        take_idx = win_idle[1:0];
                    end
                end else begin
                    turn_n = turn_cnt + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_take) begin
            state_n     = OWN;
            grant_n     = 4'b0001 << take_idx;
            sel_n       = take_idx;
            mux_blank_n = 1'b0;
            busy_n      = 1'b1;
            hold_n      = 8'd1;
        end
    end

    // State and output registers; reset blanks the mux and clears ownership immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= 8'd0;
            turn_cnt  <= 3'd0;
            grant     <= 4'b0000;
            sel       <= 2'd0;
            mux_blank <= 1'b1;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            turn_cnt  <= turn_n;
            grant     <= grant_n;
            sel       <= sel_n;
            mux_blank <= mux_blank_n;
            busy      <= busy_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_mux_94_arbiter.sv
// Bench for mux_94_arbiter: one instance with default timing, one with MAX_HOLD=4 and no turnaround.
// Latency: each vector's expected outputs are checked 1 time unit after the clock edge that consumes it.
// Backpressure: none; stimulus advances one vector per clock.
module tb_mux_94_arbiter;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [3:0] req_a = '0, last_a = '0, req_b = '0, last_b = '0;
    logic [3:0] grant_a, grant_b;
    logic [1:0] sel_a, sel_b;
    logic       blank_a, blank_b, busy_a, busy_b, timeout_a, timeout_b;
    logic [8:0] act_a, act_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_94_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .req(req_a), .last(last_a),
        .grant(grant_a), .sel(sel_a), .mux_blank(blank_a), .busy(busy_a), .timeout(timeout_a)
    );

    mux_94_arbiter #(.MAX_HOLD(4), .TURN_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(rst_b), .req(req_b), .last(last_b),
        .grant(grant_b), .sel(sel_b), .mux_blank(blank_b), .busy(busy_b), .timeout(timeout_b)
    );

    // Output vector layout: {grant[3:0], sel[1:0], mux_blank, busy, timeout}
    assign act_a = {grant_a, sel_a, blank_a, busy_a, timeout_a};
    assign act_b = {grant_b, sel_b, blank_b, busy_b, timeout_b};

    typedef struct {
        bit         rst;
        bit         dut;
        logic [3:0] req;
        logic [3:0] last;
        logic [8:0] exp;
        string      nm;
    } vec_t;

    typedef struct {
        bit         dut;
        logic [8:0] exp;
        string      nm;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic logic [8:0] e_own(int g, bit to);
        return {4'(1 << g), 2'(g), 1'b0, 1'b1, to};
    endfunction

    function automatic logic [8:0] e_blank(int s, bit to);
        return {4'b0000, 2'(s), 1'b1, 1'b0, to};
    endfunction

    task automatic add(input bit rst, input bit d, input logic [3:0] r, input logic [3:0] l,
                       input logic [8:0] e, input string nm);
        vec_t v;
        v.rst = rst; v.dut = d; v.req = r; v.last = l; v.exp = e; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: grant/sel/blank/busy/timeout got=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic do_reset(input bit d, input string nm);
        @(negedge clk);
        if (d) begin rst_b = 1'b0; req_b = '0; last_b = '0; end
        else   begin rst_a = 1'b0; req_a = '0; last_a = '0; end
        #2;
        check(nm, d ? act_b : act_a, e_blank(0, 1'b0));
        @(negedge clk);
        if (d) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    task automatic step(input bit d, input logic [3:0] r, input logic [3:0] l,
                        input logic [8:0] e, input string nm);
        sb_t s;
        sb_t got;
        @(negedge clk);
        if (d) begin req_b = r; last_b = l; end
        else   begin req_a = r; last_a = l; end
        s.dut = d; s.exp = e; s.nm = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check(got.nm, got.dut ? act_b : act_a, got.exp);
    endtask

    initial begin
        // Basic grant and last-driven release, then confirm the pointer advanced to 1.
        add(1, 0, 4'b0001, 4'b0000, e_own(0, 0),   "a1_grant");
        add(0, 0, 4'b0001, 4'b0000, e_own(0, 0),   "a1_own2");
        add(0, 0, 4'b0001, 4'b0000, e_own(0, 0),   "a1_own3");
        add(0, 0, 4'b0001, 4'b0001, e_blank(0, 0), "a1_release");
        add(0, 0, 4'b0000, 4'b0000, e_blank(0, 0), "a1_turn");
        add(0, 0, 4'b0000, 4'b1111, e_blank(0, 0), "a1_idle_last_ignored");
        add(0, 0, 4'b0011, 4'b0000, e_own(1, 0),   "a1_ptr1");
        add(0, 0, 4'b0000, 4'b0000, e_blank(1, 0), "a1_drop");
        // Full rotation with two blank cycles per handover.
        for (int g = 0; g < 4; g++) begin
            add(g == 0, 0, 4'b1111, 4'b0000,        e_own(g, 0),   $sformatf("a2_grant%0d", g));
            add(0,      0, 4'b1111, 4'b0000,        e_own(g, 0),   $sformatf("a2_word%0d", g));
            add(0,      0, 4'b1111, 4'(1 << g),     e_blank(g, 0), $sformatf("a2_rel%0d", g));
            add(0,      0, 4'b1111, 4'b0000,        e_blank(g, 0), $sformatf("a2_gap%0d", g));
        end
        add(0, 0, 4'b1111, 4'b0000, e_own(0, 0), "a2_wrap");
        // Hold limit of 8 with non-owner last bits toggling, then re-grant after turnaround.
        add(1, 0, 4'b0100, 4'b0000, e_own(2, 0), "a3_grant");
        for (int k = 2; k <= 8; k++)
            add(0, 0, 4'b0100, (k % 2) ? 4'b1011 : 4'b0000, e_own(2, 0), $sformatf("a3_hold%0d", k));
        add(0, 0, 4'b0100, 4'b0000, e_blank(2, 1), "a3_timeout");
        add(0, 0, 4'b0100, 4'b0000, e_blank(2, 0), "a3_turn");
        add(0, 0, 4'b0100, 4'b0000, e_own(2, 0),   "a3_regrant");
        // No turnaround: direct handovers, last at the hold limit, forced release, drops.
        add(1, 1, 4'b0011, 4'b0000, e_own(0, 0),   "b_grant0");
        add(0, 1, 4'b0011, 4'b0001, e_own(1, 0),   "b_handover");
        add(0, 1, 4'b0011, 4'b0000, e_own(1, 0),   "b_hold2");
        add(0, 1, 4'b0011, 4'b0000, e_own(1, 0),   "b_hold3");
        add(0, 1, 4'b0011, 4'b0000, e_own(1, 0),   "b_hold4");
        add(0, 1, 4'b0011, 4'b0010, e_own(0, 0),   "b_last_at_max");
        add(0, 1, 4'b0011, 4'b0000, e_own(0, 0),   "b0_hold2");
        add(0, 1, 4'b0011, 4'b0000, e_own(0, 0),   "b0_hold3");
        add(0, 1, 4'b0011, 4'b0000, e_own(0, 0),   "b0_hold4");
        add(0, 1, 4'b0011, 4'b0000, e_own(1, 1),   "b_timeout_handover");
        add(0, 1, 4'b0001, 4'b0000, e_own(0, 0),   "b_drop");
        add(0, 1, 4'b0010, 4'b0001, e_own(1, 0),   "b_last_and_drop");
        add(0, 1, 4'b0000, 4'b0000, e_blank(1, 0), "b_idle");
        add(0, 1, 4'b0000, 4'b1111, e_blank(1, 0), "b_idle_last");

        rst_a = 1'b0;
        rst_b = 1'b0;
        #12;
        check("reset_a", act_a, e_blank(0, 0));
        check("reset_b", act_b, e_blank(0, 0));
        rst_a = 1'b1;
        rst_b = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(vecs[i].dut, {vecs[i].nm, "_reset"});
            step(vecs[i].dut, vecs[i].req, vecs[i].last, vecs[i].exp, vecs[i].nm);
        end

        // Asynchronous reset while source 3 owns, then the pointer must be back at 0.
        do_reset(0, "r_reset");
        step(0, 4'b1000, 4'b0000, e_own(3, 0), "r_own3");
        step(0, 4'b1000, 4'b0000, e_own(3, 0), "r_own3_hold");
        @(negedge clk);
        #2 rst_a = 1'b0;
        #1 check("r_async_reset", act_a, e_blank(0, 0));
        @(negedge clk);
        rst_a = 1'b1;
        req_a = 4'b0000;
        step(0, 4'b1001, 4'b0000, e_own(0, 0), "r_ptr0");

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d entries expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
